// File: rtl/prime_seq_gen.sv
// prime_seq_gen: sweeps 2..2^WIDTH-1 and emits each prime over valid/ready.
// Primality by trial division where each division is done by repeated subtraction.
module prime_seq_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] prime,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);
    typedef enum logic [2:0] {IDLE, TEST, SUB, EMIT, ADV, DONE} state_t;
    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
    state_t state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d, div_q, div_d, rem_q, rem_d;
    logic [WIDTH-1:0] prime_q, prime_d, count_q, count_d;
    logic valid_q, valid_d, done_q, done_d;
    logic [2*WIDTH-1:0] div_sq;
    assign div_sq = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        div_d   = div_q;
        rem_d   = rem_q;
        prime_d = prime_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = TEST;
                cand_d  = TWO;
                div_d   = TWO;
                count_d = '0;
                done_d  = 1'b0;
            end
            TEST: if (div_sq > {{WIDTH{1'b0}}, cand_q}) begin
                state_d = EMIT;
                prime_d = cand_q;
                valid_d = 1'b1;
            end else begin
                rem_d   = cand_q;
                state_d = SUB;
            end
            SUB: if (rem_q >= div_q) begin
                rem_d = rem_q - div_q;
            end else if (rem_q == '0) begin
                state_d = ADV;
            end else begin
                div_d   = div_q + WIDTH'(1);
                state_d = TEST;
            end
            EMIT: if (ready) begin
                valid_d = 1'b0;
                count_d = count_q + WIDTH'(1);
                state_d = ADV;
            end
            ADV: if (cand_q == MAX) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                cand_d  = cand_q + WIDTH'(1);
                div_d   = TWO;
                state_d = TEST;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= TWO;
            div_q   <= TWO;
            rem_q   <= '0;
            prime_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            prime_q <= prime_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
    assign prime = prime_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = (state_q != IDLE) && (state_q != DONE);
endmodule

// File: tb/tb_prime_seq_gen.sv
// tb_prime_seq_gen: directed + randomized-ready checks of prime_seq_gen (WIDTH=4 and WIDTH=5)
// against a trial-division prime reference model.
module tb_prime_seq_gen;
    logic clk = 1'b0;
    logic rst_n, start, ready, valid, busy, done;
    logic [3:0] prime, count;
    logic b_rst_n, b_start, b_ready, b_valid, b_busy, b_done;
    logic [4:0] b_prime, b_count;
    int tests = 0;
    int fails = 0;
    int idx = 0;
    int exp4[$];
    int exp5[$];

    always #5 clk = ~clk;

    prime_seq_gen #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .prime(prime), .valid(valid), .busy(busy), .done(done), .count(count)
    );

    prime_seq_gen #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .ready(b_ready),
        .prime(b_prime), .valid(b_valid), .busy(b_busy), .done(b_done), .count(b_count)
    );

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One cycle with the given ready; an accepted prime is scoreboarded first.
    task automatic step(bit r);
        ready = r;
        if (valid && r) begin
            check("prime_seq", 32'(prime), idx < exp4.size() ? exp4[idx] : -1);
            idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int target);
        int n = 0;
        while (!(valid && int'(prime) == target) && n < 500) begin
            step(1'b1);
            n++;
        end
        check("run_to_reach", 32'(valid && int'(prime) == target), 1);
    endtask

    task automatic finish_sweep(bit rnd);
        int n = 0;
        while (!done && n < 2000) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check("sweep_done", 32'(done), 1);
        check("sweep_busy", 32'(busy), 0);
        check("sweep_valid", 32'(valid), 0);
        check("sweep_count", 32'(count), exp4.size());
        check("sweep_accepts", idx, exp4.size());
        check("sweep_last_prime", 32'(prime), exp4[exp4.size()-1]);
    endtask

    // Start pulse, then first prime 2 must be valid exactly two edges later.
    task automatic do_start(bit r);
        start = 1'b1;
        ready = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        ready = 1'b0;
        idx = 0;
        check("start_busy", 32'(busy), 1);
        check("start_done_clr", 32'(done), 0);
        check("start_valid_early", 32'(valid), 0);
        check("start_count_clr", 32'(count), 0);
        @(posedge clk);
        #1;
        check("first_valid", 32'(valid), 1);
        check("first_prime", 32'(prime), 2);
    endtask

    initial begin
        int bidx;
        int n;
        for (int i = 2; i < 16; i++) if (is_prime(i)) exp4.push_back(i);
        for (int i = 2; i < 32; i++) if (is_prime(i)) exp5.push_back(i);
        rst_n = 1'b0; start = 1'b0; ready = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0; b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_prime", 32'(prime), 0);
        rst_n = 1'b1;
        step(1'b1);
        check("idle_no_start", 32'(busy), 0);

        // Full sweep with ready held high, then no further valid pulses.
        do_start(1'b0);
        finish_sweep(1'b0);
        for (int i = 0; i < 5; i++) begin
            check("post_done_valid", 32'(valid), 0);
            check("post_done_hold", 32'(done), 1);
            step(1'b1);
        end
        check("post_done_prime", 32'(prime), 13);
        check("post_done_count", 32'(count), 6);

        // Backpressure on prime 5.
        do_start(1'b1);
        run_to(5);
        check("bp_count_before", 32'(count), idx);
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            check("bp_prime", 32'(prime), 5);
            check("bp_valid", 32'(valid), 1);
            check("bp_count", 32'(count), 2);
        end
        step(1'b1);
        check("bp_count_after", 32'(count), 3);
        run_to(7);
        check("bp_next_count", 32'(count), 3);
        finish_sweep(1'b1);

        // Reset mid-sweep while waiting to emit 7.
        do_start(1'b0);
        run_to(7);
        rst_n = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_prime", 32'(prime), 0);
        step(1'b0);
        check("mid_rst_idle", 32'(busy), 0);

        // Start ignored while busy at prime 11.
        do_start(1'b0);
        run_to(11);
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        step(1'b0);
        check("busy_start_valid", 32'(valid), 1);
        check("busy_start_prime", 32'(prime), 11);
        check("busy_start_count", 32'(count), 4);
        finish_sweep(1'b1);

        // Start together with ready in DONE restarts.
        do_start(1'b1);
        finish_sweep(1'b1);

        // WIDTH=5 instance with random ready.
        @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        @(posedge clk);
        #1;
        check("w5_first_valid", 32'(b_valid), 1);
        check("w5_first_prime", 32'(b_prime), 2);
        bidx = 0;
        n = 0;
        while (!b_done && n < 5000) begin
            b_ready = 1'($urandom_range(0, 1));
            if (b_valid && b_ready) begin
                check("w5_is_prime", 32'(is_prime(int'(b_prime))), 1);
                check("w5_prime_seq", 32'(b_prime), bidx < exp5.size() ? exp5[bidx] : -1);
                bidx++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("w5_done", 32'(b_done), 1);
        check("w5_busy", 32'(b_busy), 0);
        check("w5_count", 32'(b_count), 11);
        check("w5_accepts", bidx, exp5.size());
        check("w5_last_prime", 32'(b_prime), 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prime_seq_gen.md
Name: prime_seq_gen

Overview:
- Sequential prime-number generator; the producing counterpart of the combinational prime detector (4-bit number in, LED out).
- On a start pulse it sweeps candidates 2..2^WIDTH-1.
- Primality is decided by trial division using repeated subtraction, so no divider is needed.
- Each prime found is emitted over a valid/ready handshake to a consumer (detector check, display, LED driver).

Parameters:
- WIDTH, 4, bit width of candidates and output prime; sweep upper bound is 2^WIDTH-1 (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on rising edge of clk.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE, ignored otherwise.
- ready  input  1  consumer accepts prime when ready=1 and valid=1 in the same cycle.
- prime  output  WIDTH  current prime; stable while valid=1.
- valid  output  1  prime holds an unaccepted prime.
- busy  output  1  sweep in progress: any state other than IDLE and DONE.
- done  output  1  sweep finished; held until start or reset.
- count  output  WIDTH  number of primes accepted in the current sweep.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; prime=0, valid=0, busy=0, done=0, count=0.
  - Internal cand=2, div=2, rem=0.
  - Reset mid-sweep aborts immediately with no further output.
- IDLE: on start=1, go to TEST with cand=2, div=2, count=0.
- TEST:
  - Compare div*div against cand using a 2*WIDTH-bit product.
  - If div*div > cand: cand is prime; go to EMIT with prime<=cand and valid<=1 in the same edge.
  - Else: rem<=cand, go to SUB.
- SUB (one subtraction per cycle):
  - If rem >= div: rem<=rem-div, stay in SUB.
  - Else if rem==0: cand is composite; go to ADV.
  - Else: div<=div+1, go to TEST.
- EMIT:
  - valid=1 is held and prime is held constant until ready=1.
  - On the handshake edge: valid<=0, count<=count+1, go to ADV.
  - ready asserted while valid=0 has no effect.
- ADV:
  - If cand == 2^WIDTH-1: go to DONE, done<=1. No wrap to 0.
  - Else: cand<=cand+1, div<=2, go to TEST.
- DONE: done=1, valid=0; prime and count keep their last values. start=1 clears done and restarts as from IDLE.
- Latency:
  - The first prime (2) has valid=1 two cycles after the start edge (IDLE->TEST->EMIT).
  - Subsequent latency is data-dependent but bounded by the cycle count of the state machine.
  - The bench uses the handshake only, never fixed delays, except for the first prime.
- Ordering: primes are emitted strictly ascending with no duplicates or omissions. For WIDTH=4 the sequence is 2,3,5,7,11,13, ending with count=6.
- Simultaneous events:
  - rst_n=0 overrides start and ready.
  - start during a sweep (TEST/SUB/EMIT/ADV) is ignored.
  - start and ready in the same cycle in DONE: restart; ready is ignored.
- Width rules: div never exceeds 2^(WIDTH/2)+1. rem and cand are WIDTH bits. The last candidate 2^WIDTH-1 is tested before DONE.

Test Plan:
- Reset, then start pulse, ready tied 1 -> accepted primes 2,3,5,7,11,13; then done=1, busy=0, count=6, prime=13 held.
- Backpressure: ready=0 for 20 cycles while valid=1 on prime=5 -> prime stays 5, valid stays 1, count unchanged. Release ready -> count increments once and the next prime is 7.
- Reset mid-sweep: rst_n=0 while the generator is waiting to emit or emitting 7 -> next edge valid=0, busy=0, count=0, prime=0. A new start emits 2 first.
- Start ignored while busy: pulse start while the sweep is at prime 11 -> sequence continues 11,13 with no restart to 2. Start after done -> done clears and a fresh sweep begins with 2.
- WIDTH=5 instance, ready toggled pseudo-randomly -> 2,3,5,7,11,13,17,19,23,29,31 in order, count=11. Each emitted prime checked against a prime-detector reference model.
- Timing: start at cycle N -> valid=1 with prime=2 at cycle N+2. With ready held 1, the sweep ends with done=1 and no valid pulse after 13.
